aes_block_loader: RTL and testbench
===================================

# aes_block_loader

Word-stream front/back end for the AES core. Accepts four 32-bit plaintext words over a valid/ready stream and assembles them into a 128-bit block. Launches the block into the core with a one-cycle `ld` pulse and waits for `done`. Then returns the 128-bit result as four 32-bit words on an output valid/ready stream. Sits between the bus-side word FIFO and the core's `ld`/`key`/`text_in`/`done`/`text_out` pins.

## Interface
Parameters:
- `CNT_W`, 16: width of the completed-block counter.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `s_valid`  in  1  input word valid.
- `s_ready`  out  1  loader can accept an input word.
- `s_data`  in  32  input plaintext word.
- `key_in`  in  128  cipher key, sampled on the 4th input accept.
- `ld`  out  1  one-cycle launch pulse to the core.
- `key`  out  128  registered key to the core.
- `text_in`  out  128  registered plaintext block to the core.
- `done`  in  1  core result-valid pulse.
- `text_out`  in  128  core result, valid while `done`=1.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  downstream can accept an output word.
- `m_data`  out  32  output ciphertext word.
- `busy`  out  1  high in LOAD, WAIT and DRAIN.
- `blk_cnt`  out  CNT_W  count of fully drained blocks.

## Operation
- States: IDLE, FILL, LOAD, WAIT, DRAIN. Each is entered only through the transition listed with it.
- IDLE:
  - Reset state.
  - Moves to FILL unconditionally on the next cycle.
- FILL:
  - `s_ready`=1.
  - An accept is `s_valid & s_ready`.
  - Each accept writes `s_data` to word index `widx` (0..3) and increments `widx`.
  - Word 0 goes to `text_in[127:96]`, word 3 goes to `text_in[31:0]`.
  - On the accept with `widx`=3, `key_in` is captured into `key`, `widx` wraps to 0, and the state moves to LOAD.
- LOAD:
  - `ld`=1 for exactly this cycle.
  - Moves to WAIT next cycle.
- WAIT:
  - When `done`=1, `text_out` is captured into the output register and the state moves to DRAIN.
  - `done` in any other state is ignored.
- DRAIN:
  - `m_valid`=1.
  - `m_data` = output word `oidx`; word 0 = `text_out[127:96]`.
  - An output accept is `m_valid & m_ready`; each one increments `oidx`.
  - On the accept with `oidx`=3: `oidx` wraps to 0, `blk_cnt` increments (wrapping modulo 2^CNT_W), and the state moves to FILL.
- `m_data` and `m_valid` hold stable while `m_valid & ~m_ready`.
- `text_in` and `key` hold stable from LOAD until the next FILL accept.
- The key can only be updated once per block, so a single key cannot serve a partial block.
- Input and output never overlap: `s_ready`=0 outside FILL, `m_valid`=0 outside DRAIN.

## Timing
- All outputs are registered or decoded from state registers.
- Values while `rst`=0:
  - state IDLE, `widx`=`oidx`=0.
  - `s_ready`=0, `ld`=0, `m_valid`=0, `busy`=0.
  - `key`, `text_in`, `m_data` = 0.
  - `blk_cnt`=0.
- The first `s_ready`=1 occurs on the 2nd rising edge after `rst` deasserts.
- Latency:
  - 4th input accept at edge N: `ld`=1 during cycle N+1, WAIT from N+2.
  - `done` sampled at edge D: `m_valid`=1 from D+1.
- Minimum block period: 4 (fill) + 1 (load) + core latency + 4 (drain) cycles.
- `done` asserted in the same cycle WAIT is entered is captured.
- `done` during LOAD is ignored; the core guarantees `done` ≥ 1 cycle after `ld`.
- Reset asserted mid-operation:
  - Immediately clears all state and registers.
  - The partial block is discarded and `blk_cnt` returns to 0.
- `s_valid` deasserted mid-block: the loader waits indefinitely in FILL with no timeout.

## Configuration
- `AES_LOADER_BSWAP_EN` defined:
  - Each input word is byte-reversed before storage: `s_data[7:0]` lands in the word's MSB.
  - Each output word is byte-reversed before `m_data`.
  - Supports little-endian bus masters.
- Not defined: words pass unmodified.
- Timing is identical in both cases.

## Test plan
- FIPS-197 vector, stall-free:
  - Stimulus: key `000102030405060708090a0b0c0d0e0f`; words `00112233`, `44556677`, `8899aabb`, `ccddeeff`.
  - Required: `text_in`=`00112233445566778899aabbccddeeff` at `ld`, exactly one `ld` pulse.
  - Required: output words `69c4e0d8`, `6a7b0430`, `d8cdb780`, `70b4c55a`, then `blk_cnt`=1.
- Backpressure:
  - Stimulus: `m_ready` toggled 0/1 every cycle during DRAIN.
  - Required: same four words in order, each held stable while stalled, with no duplicate or dropped words.
- Input gaps and spurious `done`:
  - Stimulus: `s_valid` low 5 cycles between words 2 and 3; `done` pulsed during FILL.
  - Required: the `done` pulse is ignored and `ld` fires only after word 3.
- Reset mid-WAIT:
  - Stimulus: `rst`=0 for 2 cycles after `ld`, then a fresh block.
  - Required: all outputs read their reset values, and the fresh block yields the correct ciphertext with `blk_cnt`=1.
- Counter wrap:
  - Stimulus: CNT_W=2, 5 back-to-back blocks.
  - Required: `blk_cnt` reads 1, 2, 3, 0, 1.
- `AES_LOADER_BSWAP_EN` defined:
  - Stimulus: input word `33221100`.
  - Required: stored as `00112233`; the first output word appears as `d8e0c469`.

Source files
------------

// File: rtl/aes_block_loader.sv
// aes_block_loader
//   Word-stream front/back end for an AES core. Collects four 32-bit words
//   from a valid/ready input stream into a 128-bit block, launches the core
//   with a one-cycle ld pulse, waits for done, then returns the 128-bit
//   result as four 32-bit words on a valid/ready output stream.
//
//   Parameters:
//     CNT_W     width of the completed-block counter (wraps modulo 2^CNT_W)
//
//   Ports:
//     clk       sole clock, rising edge
//     rst       asynchronous active-low reset
//     s_valid   input word valid
//     s_ready   loader can accept an input word (FILL only)
//     s_data    input plaintext word; word 0 lands in text_in[127:96]
//     key_in    cipher key, sampled on the 4th input accept
//     ld        one-cycle launch pulse to the core
//     key       registered key to the core
//     text_in   registered plaintext block to the core
//     done      core result-valid pulse (honoured only in WAIT)
//     text_out  core result, valid while done=1
//     m_valid   output word valid (DRAIN only)
//     m_ready   downstream accepts an output word
//     m_data    output word; word 0 comes from text_out[127:96]
//     busy      high in LOAD, WAIT and DRAIN
//     blk_cnt   number of fully drained blocks
//
//   Build option:
//     AES_LOADER_BSWAP_EN  byte-reverse every input word before storage and
//                          every output word before m_data (little-endian
//                          bus masters). Timing is unchanged.

module aes_block_loader #(
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [31:0]        s_data,
  input  logic [127:0]       key_in,
  output logic               ld,
  output logic [127:0]       key,
  output logic [127:0]       text_in,
  input  logic               done,
  input  logic [127:0]       text_out,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [31:0]        m_data,
  output logic               busy,
  output logic [CNT_W-1:0]   blk_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_LOAD,
    ST_WAIT,
    ST_DRAIN
  } state_t;

  state_t         r_state;
  logic [1:0]     r_widx;
  logic [1:0]     r_oidx;
  logic [127:0]   r_out;

  logic           w_s_acc;
  logic           w_m_acc;
  logic [31:0]    w_s_word;
  logic [31:0]    w_first_out;
  logic [31:0]    w_next_out;
  logic [1:0]     w_oidx_nxt;

  // Selects 32-bit word i of a block, word 0 being the most significant.
  function automatic logic [31:0] f_word(input logic [127:0] b, input logic [1:0] i);
    logic [31:0] w;
    case (i)
      2'd0:    w = b[127:96];
      2'd1:    w = b[95:64];
      2'd2:    w = b[63:32];
      default: w = b[31:0];
    endcase
    return w;
  endfunction

`ifdef AES_LOADER_BSWAP_EN
  function automatic logic [31:0] f_bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction
`endif

  assign w_s_acc    = s_valid & s_ready;
  assign w_m_acc    = m_valid & m_ready;
  assign w_oidx_nxt = r_oidx + 2'd1;

`ifdef AES_LOADER_BSWAP_EN
  assign w_s_word    = f_bswap(s_data);
  assign w_first_out = f_bswap(text_out[127:96]);
  assign w_next_out  = f_bswap(f_word(r_out, w_oidx_nxt));
`else
  assign w_s_word    = s_data;
  assign w_first_out = text_out[127:96];
  assign w_next_out  = f_word(r_out, w_oidx_nxt);
`endif

  // Every handshake/status output is registered and updated together with
  // the state transition that implies it, so none of them is combinational.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_widx  <= '0;
      r_oidx  <= '0;
      r_out   <= '0;
      s_ready <= 1'b0;
      ld      <= 1'b0;
      m_valid <= 1'b0;
      busy    <= 1'b0;
      key     <= '0;
      text_in <= '0;
      m_data  <= '0;
      blk_cnt <= '0;
    end else begin
      ld <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_FILL;
          s_ready <= 1'b1;
        end

        ST_FILL: begin
          if (w_s_acc) begin
            case (r_widx)
              2'd0:    text_in[127:96] <= w_s_word;
              2'd1:    text_in[95:64]  <= w_s_word;
              2'd2:    text_in[63:32]  <= w_s_word;
              default: text_in[31:0]   <= w_s_word;
            endcase
            // 2-bit index wraps 3 -> 0 on its own.
            r_widx <= r_widx + 2'd1;
            if (r_widx == 2'd3) begin
              key     <= key_in;
              s_ready <= 1'b0;
              ld      <= 1'b1;
              busy    <= 1'b1;
              r_state <= ST_LOAD;
            end
          end
        end

        ST_LOAD: begin
          r_state <= ST_WAIT;
        end

        ST_WAIT: begin
          if (done) begin
            r_out   <= text_out;
            m_data  <= w_first_out;
            m_valid <= 1'b1;
            r_state <= ST_DRAIN;
          end
        end

        ST_DRAIN: begin
          if (w_m_acc) begin
            r_oidx <= w_oidx_nxt;
            if (r_oidx == 2'd3) begin
              m_valid <= 1'b0;
              busy    <= 1'b0;
              s_ready <= 1'b1;
              blk_cnt <= blk_cnt + CNT_W'(1);
              r_state <= ST_FILL;
            end else begin
              m_data <= w_next_out;
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_block_loader.sv
// Self-checking bench for aes_block_loader. A small core stub answers each
// ld pulse with done/text_out after a programmable latency; a block-level
// reference model predicts text_in, key, the output word stream and blk_cnt.
// Honours AES_LOADER_BSWAP_EN the same way as the design.

module tb_aes_block_loader;

  localparam int unsigned CNT_W = 2;

  localparam logic [127:0] FIPS_K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic               clk;
  logic               rst;
  logic               s_valid;
  logic               s_ready;
  logic [31:0]        s_data;
  logic [127:0]       key_in;
  logic               ld;
  logic [127:0]       key;
  logic [127:0]       text_in;
  logic               done;
  logic [127:0]       text_out;
  logic               m_valid;
  logic               m_ready;
  logic [31:0]        m_data;
  logic               busy;
  logic [CNT_W-1:0]   blk_cnt;

  aes_block_loader #(.CNT_W(CNT_W)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .key_in   (key_in),
    .ld       (ld),
    .key      (key),
    .text_in  (text_in),
    .done     (done),
    .text_out (text_out),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .busy     (busy),
    .blk_cnt  (blk_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [CNT_W-1:0] blk_model;

  // ---------------- reference helpers ----------------
  function automatic logic [31:0] tb_bs(input logic [31:0] x);
`ifdef AES_LOADER_BSWAP_EN
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
    return x;
`endif
  endfunction

  // Stand-in for the AES core: the FIPS-197 pair is answered exactly,
  // anything else with an arbitrary but deterministic mixing function.
  function automatic logic [127:0] core_f(input logic [127:0] p, input logic [127:0] k);
    if (p == FIPS_P && k == FIPS_K) return FIPS_C;
    return {p[63:0], p[127:64]} ^ k ^ 128'ha5a5_5a5a_0f0f_f0f0_1234_5678_9abc_def0;
  endfunction

  function automatic logic [31:0] word_of(input logic [127:0] b, input int i);
    return b[127 - 32*i -: 32];
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- core stub ----------------
  logic         core_done;
  logic         spur_done;
  logic [127:0] core_out;
  logic [127:0] cap_in, cap_key;
  int           core_lat;
  int           pend;
  int           ld_cnt;

  assign done     = core_done | spur_done;
  assign text_out = core_out;

  initial begin
    core_done = 1'b0;
    core_out  = '0;
    cap_in    = '0;
    cap_key   = '0;
    pend      = 0;
    ld_cnt    = 0;
    forever begin
      @(posedge clk); #2;
      core_done = 1'b0;
      if (!rst) pend = 0;
      else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          core_done = 1'b1;
          core_out  = core_f(cap_in, cap_key);
        end
      end
      if (rst && ld) begin
        ld_cnt++;
        cap_in  = text_in;
        cap_key = key;
        pend    = core_lat;
      end
    end
  end

  // ---------------- stimulus records ----------------
  typedef struct {
    logic [0:3][31:0] w;       // bus words as presented on s_data
    logic [127:0]     key;
    int               gap;     // idle cycles before word 3; -1 = random gaps
    bit               spur;    // pulse done during the gap
    int               bp;      // 0 always ready, 1 toggle, 2 random
    int               lat;     // core latency in cycles after ld
    logic [127:0]     exp_ct;  // ciphertext the block must drain
  } vec_t;

  function automatic vec_t mk_vec(input logic [127:0] plain, input logic [127:0] k,
                                  input int gap, input bit spur, input int bp, input int lat);
    vec_t v;
    for (int i = 0; i < 4; i++) v.w[i] = tb_bs(word_of(plain, i));
    v.key    = k;
    v.gap    = gap;
    v.spur   = spur;
    v.bp     = bp;
    v.lat    = lat;
    v.exp_ct = core_f(plain, k);
    return v;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_s_ready"}, 128'(s_ready), 128'd0);
    chk({tag, "_ld"},      128'(ld),      128'd0);
    chk({tag, "_m_valid"}, 128'(m_valid), 128'd0);
    chk({tag, "_busy"},    128'(busy),    128'd0);
    chk({tag, "_key"},     key,           128'd0);
    chk({tag, "_text_in"}, text_in,       128'd0);
    chk({tag, "_m_data"},  128'(m_data),  128'd0);
    chk({tag, "_blk_cnt"}, 128'(blk_cnt), 128'd0);
  endtask

  task automatic put_word(input logic [31:0] d);
    int t;
    t = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (!s_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!s_ready) begin
      n_cmp++; n_err++;
      $display("FAIL put_word_timeout: s_ready got 0 expected 1");
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_data  = $urandom;
  endtask

  task automatic run_block(input string tag, input vec_t v);
    logic [127:0] plain;
    logic [31:0]  held;
    bit           stalled, mr;
    int           ld0, n, t, cyc, g;
    plain = {tb_bs(v.w[0]), tb_bs(v.w[1]), tb_bs(v.w[2]), tb_bs(v.w[3])};
    core_lat = v.lat;
    ld0 = ld_cnt;
    chk({tag, "_fill_busy"},    128'(busy),    128'd0);
    chk({tag, "_fill_m_valid"}, 128'(m_valid), 128'd0);
    for (int i = 0; i < 4; i++) begin
      g = (v.gap < 0) ? int'($urandom_range(0, 2)) : ((i == 3) ? v.gap : 0);
      for (int j = 0; j < g; j++) begin
        spur_done = v.spur && (j == 1);
        @(posedge clk); #1;
        spur_done = 1'b0;
      end
      if (i == 3) begin
        chk({tag, "_no_ld_early"}, 128'(ld_cnt), 128'(ld0));
        key_in = v.key;
      end else begin
        key_in = rnd128();
      end
      put_word(v.w[i]);
    end
    key_in = rnd128();
    // one cycle after the 4th accept: launch pulse, busy, no input
    chk({tag, "_ld_pulse"}, 128'(ld),      128'd1);
    chk({tag, "_busy"},     128'(busy),    128'd1);
    chk({tag, "_s_ready"},  128'(s_ready), 128'd0);
    @(posedge clk); #1;
    chk({tag, "_ld_low"},   128'(ld),      128'd0);
    chk({tag, "_ld_count"}, 128'(ld_cnt),  128'(ld0 + 1));
    chk({tag, "_text_in"},  cap_in,        plain);
    chk({tag, "_key"},      cap_key,       v.key);

    n = 0; t = 0; cyc = 0; stalled = 1'b0; held = '0;
    while (n < 4 && t < 300) begin
      if (stalled) begin
        chk({tag, "_hold_valid"}, 128'(m_valid), 128'd1);
        chk({tag, "_hold_data"},  128'(m_data),  128'(held));
      end
      if (m_valid) begin
        if (cyc == 0) begin
          chk({tag, "_drain_s_ready"}, 128'(s_ready), 128'd0);
          chk({tag, "_drain_busy"},    128'(busy),    128'd1);
        end
        case (v.bp)
          0:       mr = 1'b1;
          1:       mr = (cyc % 2) != 0;
          default: mr = $urandom_range(0, 1) != 0;
        endcase
        m_ready = mr;
        if (mr) begin
          chk($sformatf("%s_word%0d", tag, n), 128'(m_data), 128'(tb_bs(word_of(v.exp_ct, n))));
          n++;
          stalled = 1'b0;
        end else begin
          held    = m_data;
          stalled = 1'b1;
        end
        cyc++;
      end else begin
        m_ready = 1'b0;
      end
      @(posedge clk); #1;
      t++;
    end
    m_ready = 1'b0;
    if (n < 4) begin
      n_cmp++; n_err++;
      $display("FAIL %s_drain_timeout: got %0d words expected 4", tag, n);
    end
    blk_model = blk_model + 1'b1;
    chk({tag, "_blk_cnt"},      128'(blk_cnt), 128'(blk_model));
    chk({tag, "_post_m_valid"}, 128'(m_valid), 128'd0);
    chk({tag, "_post_s_ready"}, 128'(s_ready), 128'd1);
    chk({tag, "_post_text_in"}, text_in,       plain);
    chk({tag, "_post_key"},     key,           v.key);
  endtask

  task automatic release_reset(input string tag);
    rst = 1'b1;
    blk_model = '0;
    chk({tag, "_rel_s_ready"}, 128'(s_ready), 128'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk({tag, "_first_s_ready"}, 128'(s_ready), 128'd1);
  endtask

  // ---------------- main sequence ----------------
  vec_t tv[5];

  initial begin
    rst = 1'b0; s_valid = 1'b0; s_data = '0; key_in = '0;
    m_ready = 1'b0; spur_done = 1'b0; core_lat = 1; blk_model = '0;

    tv[0] = mk_vec(FIPS_P, FIPS_K, 0,  1'b0, 0, 1);
    tv[1] = mk_vec(FIPS_P, FIPS_K, 0,  1'b0, 1, 3);
    tv[2] = mk_vec(FIPS_P, FIPS_K, 5,  1'b1, 0, 2);
    tv[3] = mk_vec(rnd128(), rnd128(), -1, 1'b0, 2, int'($urandom_range(1, 6)));
    tv[4] = mk_vec(rnd128(), rnd128(), -1, 1'b0, 2, int'($urandom_range(1, 6)));

    // power-on reset, with inputs wiggling
    s_valid = 1'b1; s_data = $urandom; key_in = rnd128();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("por");
    s_valid = 1'b0;
    release_reset("por");

    // table: FIPS stall-free, backpressure, gaps+spurious done, random
    for (int i = 0; i < 5; i++) run_block($sformatf("tv%0d", i), tv[i]);

    // reset while waiting on the core, then a fresh block
    core_lat = 20;
    key_in = FIPS_K;
    for (int i = 0; i < 4; i++) put_word(tb_bs(word_of(FIPS_P, i)));
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rstwait_busy", 128'(busy), 128'd1);
    rst = 1'b0;
    #1;
    chk_reset_vals("rstwait_now");
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_reset_vals("rstwait_held");
    release_reset("rstwait");
    run_block("after_rst", tv[0]);

    // counter wrap with CNT_W=2: expect 1,2,3,0,1
    rst = 1'b0;
    @(posedge clk); #1;
    release_reset("wrap");
    for (int i = 0; i < 5; i++)
      run_block($sformatf("wrap%0d", i),
                mk_vec(rnd128(), rnd128(), -1, 1'b0, 2, int'($urandom_range(1, 6))));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    n_cmp++; n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
